// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//
// Three requesters share one memory port:
//   0 = reference-point fetch, 1 = query-point fetch, 2 = KNN-ID writeback.
// Each cycle one eligible requester is picked. The arbiter then drives
// LOAD/STORE on the memory port. The memory accepts a command by returning a
// nonzero transaction tag in the same cycle. Accepted loads are recorded in a
// tag table together with their owner. When data later returns on that tag,
// it is routed back to the owner and the entry is freed.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   req_valid/req_is_store    per-requester request and type (1 = STORE)
//   req_addr/req_wdata        per-requester address and store data, packed
//                             with requester i in slice [i*W +: W]
//   req_ready                 request accepted this cycle (one-hot or zero)
//   resp_valid/resp_data      routed load data; resp_data is 0 when idle
//   mem2proc_*                memory-side accept tag, return data and tag
//   proc2mem_*                command (0 NONE, 1 LOAD, 2 STORE), addr, data
//   idle                      no in-flight loads and no pending request
//   tag_err                   sticky: data came back on an unknown tag
module mem_req_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int NUM_TAGS    = 16,
    parameter int MAX_OUTST   = 4,
    parameter int WB_PRIORITY = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TAG_W       = $clog2(NUM_TAGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_is_store,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    input  logic [TAG_W-1:0]          mem2proc_transaction_tag,
    input  logic [DATA_W-1:0]         mem2proc_data,
    input  logic [TAG_W-1:0]          mem2proc_data_tag,
    output logic [1:0]                proc2mem_command,
    output logic [ADDR_W-1:0]         proc2mem_addr,
    output logic [DATA_W-1:0]         proc2mem_data,
    output logic                      idle,
    output logic                      tag_err
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int WB_ID = NUM_REQ - 1;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    // Registered state
    logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_TAGS-1:0] tbl_valid_q, tbl_valid_d;
    logic [OWN_W-1:0]    tbl_owner_q [NUM_TAGS];
    logic [OWN_W-1:0]    tbl_owner_d [NUM_TAGS];
    logic [CNT_W-1:0]    outst_q [NUM_REQ];
    logic [CNT_W-1:0]    outst_d [NUM_REQ];
    logic                tag_err_q, tag_err_d;

    // Combinational helpers
    logic [NUM_REQ-1:0]  eligible;
    logic [OWN_W-1:0]    cand [NUM_REQ];
    logic                grant_any;
    logic [OWN_W-1:0]    grant_idx;
    logic                accept;
    logic                accept_load;
    logic                ret_tag_nz;
    logic                ret_hit;
    logic [OWN_W-1:0]    ret_owner;
    logic                any_outst;

    // Stores never occupy a tag, so only loads are throttled by the
    // per-requester outstanding limit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] &&
                          (req_is_store[i] || (outst_q[i] < CNT_W'(MAX_OUTST)));
        end
    end

    // Round-robin search order: cand[0] is rr_ptr, then it wraps upward.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            cand[k] = OWN_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        end
    end

    // The writeback requester preempts round-robin when priority is enabled.
    // Otherwise the first eligible requester in rotated order wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if ((WB_PRIORITY != 0) && eligible[WB_ID]) begin
            grant_any = 1'b1;
            grant_idx = OWN_W'(WB_ID);
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && eligible[cand[k]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[k];
                end
            end
        end
    end

    // Memory command drive. Everything is forced quiet while in reset.
    // Ready only goes high when the memory accepts the command this cycle.
    always_comb begin
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        req_ready        = '0;
        if (rst && grant_any) begin
            proc2mem_command     = req_is_store[grant_idx] ? CMD_STORE : CMD_LOAD;
            proc2mem_addr        = req_addr[grant_idx*ADDR_W +: ADDR_W];
            proc2mem_data        = req_wdata[grant_idx*DATA_W +: DATA_W];
            req_ready[grant_idx] = (mem2proc_transaction_tag != '0);
        end
    end

    assign accept      = |req_ready;
    assign accept_load = accept && !req_is_store[grant_idx];

    assign ret_tag_nz = (mem2proc_data_tag != '0);
    assign ret_hit    = ret_tag_nz && tbl_valid_q[mem2proc_data_tag];
    assign ret_owner  = tbl_owner_q[mem2proc_data_tag];

    // Returned data is routed to its owner in the same cycle. There is no
    // backpressure, so the owner must take it immediately.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (rst && ret_hit) begin
            resp_valid[ret_owner] = 1'b1;
            resp_data             = mem2proc_data;
        end
    end

    always_comb begin
        any_outst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            any_outst = any_outst | (outst_q[i] != '0);
        end
    end

    assign idle    = !any_outst && (req_valid == '0);
    assign tag_err = tag_err_q;

    // Next-state logic. The free is applied before the allocate, so a tag
    // that is returned and re-issued in the same cycle ends up valid with
    // its new owner. Counters take +1 and -1 together, which leaves a
    // requester with a simultaneous accept and return unchanged.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        tbl_valid_d = tbl_valid_q;
        tbl_owner_d = tbl_owner_q;
        outst_d     = outst_q;
        tag_err_d   = tag_err_q;

        if (accept) begin
            rr_ptr_d = (grant_idx == OWN_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end

        if (ret_hit) begin
            tbl_valid_d[mem2proc_data_tag] = 1'b0;
        end
        if (ret_tag_nz && !tbl_valid_q[mem2proc_data_tag]) begin
            tag_err_d = 1'b1;
        end

        if (accept_load) begin
            tbl_valid_d[mem2proc_transaction_tag] = 1'b1;
            tbl_owner_d[mem2proc_transaction_tag] = grant_idx;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            outst_d[i] = outst_q[i]
                       + CNT_W'(accept_load && (grant_idx == OWN_W'(i)))
                       - CNT_W'(ret_hit && (ret_owner == OWN_W'(i)));
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            tbl_valid_q <= '0;
            tbl_owner_q <= '{default: '0};
            outst_q     <= '{default: '0};
            tag_err_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_owner_q <= tbl_owner_d;
            outst_q     <= outst_d;
            tag_err_q   <= tag_err_d;
        end
    end

endmodule
